// File: rtl/rv_branch_predict_resolve.sv
// Branch resolution and hazard unit: bimodal BHT prediction in fetch, branch/jump
// resolution in execute, a multi-cycle flush sequencer and saturating perf counters.
module rv_branch_predict_resolve #(
  parameter int XLEN         = 32,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_predict_taken,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_func3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_predicted,
  input  logic             ex_zero,
  input  logic             ex_lt,
  input  logic             ex_ltu,
  output logic             redirect,
  output logic [1:0]       redirect_sel,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IW = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] FC_INIT   = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSHING} state_t;

  state_t           state_q, state_d;
  logic [2:0]       fc_q, fc_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  logic [IW-1:0] f_idx, ex_idx;
  logic          flush_busy, live, is_jump, taken, br_ok, br_live, jump_live, mispredict;
  logic          unused_pc_bits;

  assign f_idx  = f_pc[IW+1:2];
  assign ex_idx = ex_pc[IW+1:2];
  assign unused_pc_bits = ^{f_pc[XLEN-1:IW+2], f_pc[1:0], ex_pc[XLEN-1:IW+2], ex_pc[1:0]};

  assign f_predict_taken  = bht_q[f_idx][1];
  assign br_count         = br_count_q;
  assign mispredict_count = mp_count_q;

  // While the sequencer is flushing, the instruction in execute is the squashed one.
  always_comb begin
    flush_busy = (state_q == FLUSHING);
    live       = ex_valid & ~stall & ~flush_busy;
    is_jump    = (ex_opcode == OP_JAL) | (ex_opcode == OP_JALR);
    br_ok      = 1'b1;
    case (ex_func3)
      3'b000:  taken = ex_zero;
      3'b001:  taken = ~ex_zero;
      3'b100:  taken = ex_lt;
      3'b101:  taken = ~ex_lt;
      3'b110:  taken = ex_ltu;
      3'b111:  taken = ~ex_ltu;
      default: begin
        taken = 1'b0;
        br_ok = 1'b0;
      end
    endcase
    br_live    = live & (ex_opcode == OP_BRANCH) & br_ok;
    jump_live  = live & is_jump;
    mispredict = br_live & (taken != ex_predicted);
    redirect   = jump_live | mispredict;
    if (jump_live || (mispredict && taken)) begin
      redirect_sel = 2'b01;
    end else if (mispredict) begin
      redirect_sel = 2'b10;
    end else begin
      redirect_sel = 2'b00;
    end
    flush = flush_busy | redirect;
  end

  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    bht_d      = bht_q;
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (!stall) begin
      case (state_q)
        IDLE: begin
          if (redirect && (FLUSH_CYCLES > 1)) begin
            state_d = FLUSHING;
            fc_d    = FC_INIT;
          end
        end
        FLUSHING: begin
          if (fc_q <= 3'd1) begin
            state_d = IDLE;
            fc_d    = 3'd0;
          end else begin
            fc_d = fc_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // 2-bit saturating counters; br_live already excludes stalled cycles.
    if (br_live) begin
      if (taken) begin
        if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
      end else begin
        if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
      end
      if (br_count_q != '1) br_count_d = br_count_q + CNT_W'(1);
    end
    if (mispredict && (mp_count_q != '1)) mp_count_d = mp_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fc_q       <= 3'd0;
      br_count_q <= '0;
      mp_count_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
      bht_q      <= bht_d;
    end
  end

endmodule

// File: tb/tb_rv_branch_predict_resolve.sv
// Scoreboard bench for rv_branch_predict_resolve: a behavioural model pushes the
// expected outputs per cycle; each scenario task pops and compares them inline.
module tb_rv_branch_predict_resolve;

  localparam int XLEN         = 32;
  localparam int BHT_ENTRIES  = 16;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  localparam logic [6:0] OPB    = 7'b1100011;
  localparam logic [6:0] OPJAL  = 7'b1101111;
  localparam logic [6:0] OPJALR = 7'b1100111;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  f_pc;
  logic             f_predict_taken;
  logic             stall;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [2:0]       ex_func3;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_predicted;
  logic             ex_zero, ex_lt, ex_ltu;
  logic             redirect;
  logic [1:0]       redirect_sel;
  logic             flush;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispredict_count;

  always #5 clk = ~clk;

  rv_branch_predict_resolve #(
    .XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_predict_taken(f_predict_taken), .stall(stall),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_pc(ex_pc),
    .ex_predicted(ex_predicted), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .redirect(redirect), .redirect_sel(redirect_sel), .flush(flush),
    .br_count(br_count), .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic        p, z, lt, ltu, st;
    logic [31:0] fpc;
  } stim_t;

  // ctrl = {redirect, redirect_sel, flush, f_predict_taken}; cnt = {br_count, mispredict_count}
  typedef struct {
    logic [4:0]         ctrl;
    logic [2*CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  int   bht_m [BHT_ENTRIES];
  int   brc_m, mpc_m, flush_left;
  logic pend_lbr, pend_taken, pend_mis, pend_rd, pend_st;
  int   pend_idx;

  function automatic stim_t mk(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] pc, input logic p, input logic z,
                               input logic lt, input logic ltu, input logic st,
                               input logic [31:0] fpc);
    stim_t s;
    s.v = v; s.op = op; s.f3 = f3; s.pc = pc; s.p = p;
    s.z = z; s.lt = lt; s.ltu = ltu; s.st = st; s.fpc = fpc;
    return s;
  endfunction

  function automatic stim_t idle(input logic st, input logic [31:0] fpc);
    return mk(1'b0, 7'h00, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, st, fpc);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_ENTRIES; i++) bht_m[i] = 1;
    brc_m = 0; mpc_m = 0; flush_left = 0;
    pend_lbr = 0; pend_taken = 0; pend_mis = 0; pend_rd = 0; pend_st = 0; pend_idx = 0;
    sb.delete();
  endtask

  // Drive one execute cycle, push the model's expectation, then wait to the sampling edge.
  task automatic drive(input stim_t s);
    logic busy, live, is_br, is_jmp, ok, t, lbr, ljmp, mis, rd;
    logic [1:0] sel;
    exp_t e;
    f_pc = s.fpc; stall = s.st; ex_valid = s.v; ex_opcode = s.op; ex_func3 = s.f3;
    ex_pc = s.pc; ex_predicted = s.p; ex_zero = s.z; ex_lt = s.lt; ex_ltu = s.ltu;
    busy   = (flush_left > 0);
    live   = s.v && !s.st && !busy;
    is_br  = (s.op == OPB);
    is_jmp = (s.op == OPJAL) || (s.op == OPJALR);
    ok = 1'b1;
    case (s.f3)
      3'b000: t = s.z;
      3'b001: t = !s.z;
      3'b100: t = s.lt;
      3'b101: t = !s.lt;
      3'b110: t = s.ltu;
      3'b111: t = !s.ltu;
      default: begin t = 1'b0; ok = 1'b0; end
    endcase
    lbr  = live && is_br && ok;
    ljmp = live && is_jmp;
    mis  = lbr && (t != s.p);
    rd   = ljmp || mis;
    sel  = ljmp ? 2'b01 : (mis ? (t ? 2'b01 : 2'b10) : 2'b00);
    e.ctrl = {rd, sel, busy || rd, (bht_m[(s.fpc >> 2) % BHT_ENTRIES] >= 2)};
    e.cnt  = {CNT_W'(brc_m), CNT_W'(mpc_m)};
    sb.push_back(e);
    pend_lbr = lbr; pend_taken = t; pend_mis = mis; pend_rd = rd; pend_st = s.st;
    pend_idx = (s.pc >> 2) % BHT_ENTRIES;
    @(negedge clk);
  endtask

  // Advance through the clock edge and retire the cycle into the model.
  task automatic tick();
    @(posedge clk);
    if (pend_lbr) begin
      if (pend_taken && bht_m[pend_idx] < 3) bht_m[pend_idx]++;
      if (!pend_taken && bht_m[pend_idx] > 0) bht_m[pend_idx]--;
      if (brc_m < CNT_MAX) brc_m++;
    end
    if (pend_mis && mpc_m < CNT_MAX) mpc_m++;
    if (!pend_st) begin
      if (flush_left > 0) flush_left--;
      else if (pend_rd) flush_left = FLUSH_CYCLES - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    f_pc = '0; stall = 0; ex_valid = 0; ex_opcode = '0; ex_func3 = '0; ex_pc = '0;
    ex_predicted = 0; ex_zero = 0; ex_lt = 0; ex_ltu = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({redirect, redirect_sel, flush, f_predict_taken, br_count, mispredict_count} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs got %b want 0",
               {redirect, redirect_sel, flush, f_predict_taken, br_count, mispredict_count});
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(idle(1'b0, 32'(i * 4)));
      e = sb.pop_front();
      compared++;
      if ({redirect, redirect_sel, flush, f_predict_taken} !== e.ctrl) begin
        mismatched++;
        $display("[TB] FAIL reset_sweep[%0d] ctrl got %b want %b", i,
                 {redirect, redirect_sel, flush, f_predict_taken}, e.ctrl);
      end
      compared++;
      if ({br_count, mispredict_count} !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL reset_sweep[%0d] cnt got %h want %h", i, {br_count, mispredict_count}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_beq_mispredict();
    stim_t seq [3];
    exp_t  e;
    seq[0] = mk(1, OPB, 3'b000, 32'h10, 0, 1, 0, 0, 0, 32'h10);
    seq[1] = idle(0, 32'h10);
    seq[2] = idle(0, 32'h10);
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      compared++;
      if ({redirect, redirect_sel, flush, f_predict_taken} !== e.ctrl) begin
        mismatched++;
        $display("[TB] FAIL beq[%0d] ctrl got %b want %b", i,
                 {redirect, redirect_sel, flush, f_predict_taken}, e.ctrl);
      end
      compared++;
      if ({br_count, mispredict_count} !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL beq[%0d] cnt got %h want %h", i, {br_count, mispredict_count}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_bne_saturate();
    stim_t seq [7];
    exp_t  e;
    seq[0] = mk(1, OPB, 3'b001, 32'h20, 1, 1, 0, 0, 0, 32'h20);
    seq[1] = idle(0, 32'h20);
    seq[2] = idle(0, 32'h20);
    seq[3] = mk(1, OPB, 3'b001, 32'h20, 0, 1, 0, 0, 0, 32'h20);
    seq[4] = idle(0, 32'h20);
    seq[5] = mk(1, OPB, 3'b001, 32'h20, 0, 1, 0, 0, 0, 32'h20);
    seq[6] = idle(0, 32'h20);
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      compared++;
      if ({redirect, redirect_sel, flush, f_predict_taken} !== e.ctrl) begin
        mismatched++;
        $display("[TB] FAIL bne[%0d] ctrl got %b want %b", i,
                 {redirect, redirect_sel, flush, f_predict_taken}, e.ctrl);
      end
      compared++;
      if ({br_count, mispredict_count} !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL bne[%0d] cnt got %h want %h", i, {br_count, mispredict_count}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_unsigned();
    stim_t seq [5];
    exp_t  e;
    seq[0] = mk(1, OPB, 3'b110, 32'h30, 1, 0, 0, 1, 0, 32'h30);
    seq[1] = mk(1, OPB, 3'b111, 32'h34, 0, 0, 0, 1, 0, 32'h30);
    seq[2] = mk(1, OPB, 3'b010, 32'h30, 1, 1, 0, 0, 0, 32'h30);
    seq[3] = idle(0, 32'h30);
    seq[4] = idle(0, 32'h34);
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      compared++;
      if ({redirect, redirect_sel, flush, f_predict_taken} !== e.ctrl) begin
        mismatched++;
        $display("[TB] FAIL unsigned[%0d] ctrl got %b want %b", i,
                 {redirect, redirect_sel, flush, f_predict_taken}, e.ctrl);
      end
      compared++;
      if ({br_count, mispredict_count} !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL unsigned[%0d] cnt got %h want %h", i, {br_count, mispredict_count}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_jal_stall();
    stim_t seq [11];
    exp_t  e;
    seq[0]  = mk(1, OPB, 3'b000, 32'h14, 0, 1, 0, 0, 0, 32'h14);
    seq[1]  = mk(1, OPJAL, 3'b000, 32'h14, 0, 0, 0, 0, 0, 32'h14);
    seq[2]  = idle(0, 32'h14);
    seq[3]  = mk(1, OPJAL, 3'b000, 32'h14, 0, 0, 0, 0, 1, 32'h14);
    seq[4]  = mk(1, OPJAL, 3'b000, 32'h14, 0, 0, 0, 0, 0, 32'h14);
    seq[5]  = idle(1, 32'h14);
    seq[6]  = idle(0, 32'h14);
    seq[7]  = idle(0, 32'h14);
    seq[8]  = mk(1, OPJALR, 3'b000, 32'h14, 1, 0, 0, 0, 0, 32'h14);
    seq[9]  = idle(0, 32'h14);
    seq[10] = idle(0, 32'h14);
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb.pop_front();
      compared++;
      if ({redirect, redirect_sel, flush, f_predict_taken} !== e.ctrl) begin
        mismatched++;
        $display("[TB] FAIL jal[%0d] ctrl got %b want %b", i,
                 {redirect, redirect_sel, flush, f_predict_taken}, e.ctrl);
      end
      compared++;
      if ({br_count, mispredict_count} !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL jal[%0d] cnt got %h want %h", i, {br_count, mispredict_count}, e.cnt);
      end
      tick();
    end
  endtask

  task automatic test_counter_saturation();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      drive(mk(1, OPB, 3'b000, 32'h3C, 0, 0, 0, 0, 0, 32'h3C));
      e = sb.pop_front();
      compared++;
      if ({br_count, mispredict_count} !== e.cnt) begin
        mismatched++;
        $display("[TB] FAIL sat[%0d] cnt got %h want %h", i, {br_count, mispredict_count}, e.cnt);
      end
      tick();
    end
    compared++;
    if (br_count !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL sat_final br_count got %h want f", br_count);
    end
  endtask

  task automatic test_reset_mid_flush();
    exp_t e;
    drive(mk(1, OPB, 3'b000, 32'h10, 0, 1, 0, 0, 0, 32'h10));
    e = sb.pop_front();
    compared++;
    if ({redirect, redirect_sel, flush} !== e.ctrl[4:1]) begin
      mismatched++;
      $display("[TB] FAIL rstflush_redirect got %b want %b", {redirect, redirect_sel, flush}, e.ctrl[4:1]);
    end
    tick();
    ex_valid = 1'b0;
    #1;
    compared++;
    if (flush !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstflush_busy flush got %b want 1", flush);
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({flush, redirect, br_count, mispredict_count} !== '0) begin
      mismatched++;
      $display("[TB] FAIL rstflush_async got %b want 0", {flush, redirect, br_count, mispredict_count});
    end
    model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      drive(idle(1'b0, 32'(i * 4)));
      e = sb.pop_front();
      compared++;
      if ({redirect, redirect_sel, flush, f_predict_taken} !== e.ctrl) begin
        mismatched++;
        $display("[TB] FAIL rstflush_sweep[%0d] ctrl got %b want %b", i,
                 {redirect, redirect_sel, flush, f_predict_taken}, e.ctrl);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bne_saturate();
    test_unsigned();
    test_jal_stall();
    test_counter_saturation();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
